msgpass_buff_access_ctrl: RTL and testbench

MSGPASS_BUFF_ACCESS_CTRL -- requirements
Module: msgpass_buff_access_ctrl

---
 rtl/msgPass_config_pkg.sv | 17 +
 rtl/msgpass_buff_access_ctrl_pkg.sv | 29 ++
 rtl/msgpass_buff_access_ctrl_if.sv | 41 ++++
 rtl/msgpass_port_issue.sv | 74 +++++++
 rtl/msgpass_buff_access_ctrl.sv | 110 +++++++++++
 tb/tb_msgpass_buff_access_ctrl.sv | 254 +++++++++++++++++++++++++
 6 files changed

// File: rtl/msgPass_config_pkg.sv
// Purpose : shared buffer geometry for the message-passing buffer plus the per-port request record.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package msgPass_config_pkg;

  localparam int MSGPASS_BUFF_ADDR_WIDTH  = 8;
  localparam int MSGPASS_BUFF_RDATA_WIDTH = 32;

  // One operation presented to a buffer port in a given cycle.
  typedef struct packed {
    logic                                valid;
    logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  addr;
    logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] data;
    logic                                is_write;
  } msgpass_port_req_t;

endpackage

// File: rtl/msgpass_buff_access_ctrl_pkg.sv
// Purpose : local aliases and the request-builder helper for the buffer access controller.
// Latency : n/a (types and functions only).
// Backpr. : n/a.
package msgpass_buff_access_ctrl_pkg;

  import msgPass_config_pkg::*;

  localparam int AW = MSGPASS_BUFF_ADDR_WIDTH;
  localparam int DW = MSGPASS_BUFF_RDATA_WIDTH;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;

  // Folds the accepted write/read of one client into a single port request.
  // The ready logic never accepts both on the same port, so the write simply wins the mux.
  function automatic msgpass_port_req_t make_req(input logic  wr_acc,
                                                 input addr_t wr_addr,
                                                 input data_t wr_data,
                                                 input logic  rd_acc,
                                                 input addr_t rd_addr);
    msgpass_port_req_t req;
    req.valid    = wr_acc | rd_acc;
    req.is_write = wr_acc;
    req.addr     = wr_acc ? wr_addr : rd_addr;
    req.data     = wr_acc ? wr_data : '0;
    return req;
  endfunction

endpackage

// File: rtl/msgpass_buff_access_ctrl_if.sv
// Purpose : client-side write, read-request and read-response channels for clients a and b.
// Latency : n/a (wiring only).
// Backpr. : valid/ready on the write and read-request channels; read responses cannot be stalled.
interface msgpass_buff_access_ctrl_if;

  import msgpass_buff_access_ctrl_pkg::*;

  logic  wr_valid_a_i, wr_ready_a_o;
  addr_t wr_addr_a_i;
  data_t wr_data_a_i;
  logic  wr_valid_b_i, wr_ready_b_o;
  addr_t wr_addr_b_i;
  data_t wr_data_b_i;

  logic  rd_valid_a_i, rd_ready_a_o;
  addr_t rd_addr_a_i;
  logic  rd_valid_b_i, rd_ready_b_o;
  addr_t rd_addr_b_i;

  logic  rd_rvalid_a_o, rd_rvalid_b_o;
  data_t rd_rdata_a_o, rd_rdata_b_o;

  // Controller side.
  modport slave (
    input  wr_valid_a_i, wr_addr_a_i, wr_data_a_i,
    input  wr_valid_b_i, wr_addr_b_i, wr_data_b_i,
    input  rd_valid_a_i, rd_addr_a_i, rd_valid_b_i, rd_addr_b_i,
    output wr_ready_a_o, wr_ready_b_o, rd_ready_a_o, rd_ready_b_o,
    output rd_rvalid_a_o, rd_rdata_a_o, rd_rvalid_b_o, rd_rdata_b_o
  );

  // Client side.
  modport master (
    output wr_valid_a_i, wr_addr_a_i, wr_data_a_i,
    output wr_valid_b_i, wr_addr_b_i, wr_data_b_i,
    output rd_valid_a_i, rd_addr_a_i, rd_valid_b_i, rd_addr_b_i,
    input  wr_ready_a_o, wr_ready_b_o, rd_ready_a_o, rd_ready_b_o,
    input  rd_rvalid_a_o, rd_rdata_a_o, rd_rvalid_b_o, rd_rdata_b_o
  );

endinterface

// File: rtl/msgpass_port_issue.sv
// Purpose : registers one accepted operation onto a buffer port and tracks the read response.
// Latency : write strobe 1 cycle after acceptance; read response 2 cycles after acceptance.
// Backpr. : none; one request per cycle is always absorbed.
// Ports   : clk_i/rstn; i_req (accepted op); i_buff_rdata (buffer registered read data);
//           o_buff_wen (active low), o_buff_waddr/wdata/raddr; o_rvalid/o_rdata (client response).
module msgpass_port_issue
  import msgPass_config_pkg::*;
  import msgpass_buff_access_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn,
  input  msgpass_port_req_t i_req,
  input  data_t             i_buff_rdata,
  output logic              o_buff_wen,
  output addr_t             o_buff_waddr,
  output data_t             o_buff_wdata,
  output addr_t             o_buff_raddr,
  output logic              o_rvalid,
  output data_t             o_rdata
);

  logic  r_wen;
  addr_t r_waddr;
  data_t r_wdata;
  addr_t r_raddr;
  logic  r_rd_issue;  // read address is on the buffer this cycle
  logic  r_rd_s1;     // buffer read data is valid this cycle
  logic  r_rvalid;
  data_t r_rdata;

  logic w_is_wr;
  logic w_is_rd;

  assign w_is_wr = i_req.valid & i_req.is_write;
  assign w_is_rd = i_req.valid & ~i_req.is_write;

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      r_wen      <= 1'b1;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_raddr    <= '0;
      r_rd_issue <= 1'b0;
      r_rd_s1    <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      // Strobe is one cycle wide because it is recomputed from each cycle's request.
      r_wen <= ~w_is_wr;
      if (w_is_wr) begin
        r_waddr <= i_req.addr;
        r_wdata <= i_req.data;
      end
      if (w_is_rd) begin
        r_raddr <= i_req.addr;
      end
      r_rd_issue <= w_is_rd;
      r_rd_s1    <= r_rd_issue;
      r_rvalid   <= r_rd_s1;
      // Capture here so back-to-back reads each return their own word.
      if (r_rd_s1) begin
        r_rdata <= i_buff_rdata;
      end
    end
  end

  assign o_buff_wen   = r_wen;
  assign o_buff_waddr = r_waddr;
  assign o_buff_wdata = r_wdata;
  assign o_buff_raddr = r_raddr;
  assign o_rvalid     = r_rvalid;
  assign o_rdata      = r_rdata;

endmodule

// File: rtl/msgpass_buff_access_ctrl.sv
// Purpose : arbitrates two clients onto a dual-port buffer; resolves same-address write collisions.
// Latency : write strobe 1 cycle after acceptance; read response 2 cycles after acceptance.
// Backpr. : ready is combinational from current valid/address and registered priority; reads yield to writes.
// Ports   : clk_i/rstn; bus (client channels a/b, slave side); buff_*_portA/B (buffer drive and read data);
//           conflict_cnt_o (saturating count of resolved write collisions).
module msgpass_buff_access_ctrl
  import msgPass_config_pkg::*;
  import msgpass_buff_access_ctrl_pkg::*;
#(
  parameter int CONFLICT_CNT_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn,
  msgpass_buff_access_ctrl_if.slave     bus,
  output logic                          buff_wen_portA_o,
  output addr_t                         buff_waddr_portA_o,
  output data_t                         buff_wdata_portA_o,
  output addr_t                         buff_raddr_portA_o,
  input  data_t                         buff_rdata_portA_i,
  output logic                          buff_wen_portB_o,
  output addr_t                         buff_waddr_portB_o,
  output data_t                         buff_wdata_portB_o,
  output addr_t                         buff_raddr_portB_o,
  input  data_t                         buff_rdata_portB_i,
  output logic [CONFLICT_CNT_WIDTH-1:0] conflict_cnt_o
);

  logic                          r_prio_b;
  logic [CONFLICT_CNT_WIDTH-1:0] r_conflict_cnt;

  logic w_collision;
  logic w_wr_ready_a, w_wr_ready_b;
  logic w_wr_acc_a, w_wr_acc_b;
  logic w_haz_a, w_haz_b;
  logic w_rd_ready_a, w_rd_ready_b;
  logic w_rd_acc_a, w_rd_acc_b;

  msgpass_port_req_t w_req_a, w_req_b;

  assign w_collision = bus.wr_valid_a_i & bus.wr_valid_b_i &
                       (bus.wr_addr_a_i == bus.wr_addr_b_i);

  // Collision loser is held off; otherwise both write channels are open.
  assign w_wr_ready_a = rstn & ~(w_collision &  r_prio_b);
  assign w_wr_ready_b = rstn & ~(w_collision & ~r_prio_b);
  assign w_wr_acc_a   = bus.wr_valid_a_i & w_wr_ready_a;
  assign w_wr_acc_b   = bus.wr_valid_b_i & w_wr_ready_b;

  // A read of an address being written this cycle would see stale data; hold it one cycle.
  assign w_haz_a = (w_wr_acc_a & (bus.rd_addr_a_i == bus.wr_addr_a_i)) |
                   (w_wr_acc_b & (bus.rd_addr_a_i == bus.wr_addr_b_i));
  assign w_haz_b = (w_wr_acc_a & (bus.rd_addr_b_i == bus.wr_addr_a_i)) |
                   (w_wr_acc_b & (bus.rd_addr_b_i == bus.wr_addr_b_i));

  // A pending write owns its port for the cycle.
  assign w_rd_ready_a = rstn & ~bus.wr_valid_a_i & ~w_haz_a;
  assign w_rd_ready_b = rstn & ~bus.wr_valid_b_i & ~w_haz_b;
  assign w_rd_acc_a   = bus.rd_valid_a_i & w_rd_ready_a;
  assign w_rd_acc_b   = bus.rd_valid_b_i & w_rd_ready_b;

  assign bus.wr_ready_a_o = w_wr_ready_a;
  assign bus.wr_ready_b_o = w_wr_ready_b;
  assign bus.rd_ready_a_o = w_rd_ready_a;
  assign bus.rd_ready_b_o = w_rd_ready_b;

  // A collision always resolves in its own cycle, so flip priority and count on every one.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      r_prio_b       <= 1'b0;
      r_conflict_cnt <= '0;
    end else if (w_collision) begin
      r_prio_b <= ~r_prio_b;
      if (r_conflict_cnt != {CONFLICT_CNT_WIDTH{1'b1}}) begin
        r_conflict_cnt <= r_conflict_cnt + CONFLICT_CNT_WIDTH'(1);
      end
    end
  end

  assign conflict_cnt_o = r_conflict_cnt;

  assign w_req_a = make_req(w_wr_acc_a, bus.wr_addr_a_i, bus.wr_data_a_i, w_rd_acc_a, bus.rd_addr_a_i);
  assign w_req_b = make_req(w_wr_acc_b, bus.wr_addr_b_i, bus.wr_data_b_i, w_rd_acc_b, bus.rd_addr_b_i);

  msgpass_port_issue u_issue_a (
    .clk_i        (clk_i),
    .rstn         (rstn),
    .i_req        (w_req_a),
    .i_buff_rdata (buff_rdata_portA_i),
    .o_buff_wen   (buff_wen_portA_o),
    .o_buff_waddr (buff_waddr_portA_o),
    .o_buff_wdata (buff_wdata_portA_o),
    .o_buff_raddr (buff_raddr_portA_o),
    .o_rvalid     (bus.rd_rvalid_a_o),
    .o_rdata      (bus.rd_rdata_a_o)
  );

  msgpass_port_issue u_issue_b (
    .clk_i        (clk_i),
    .rstn         (rstn),
    .i_req        (w_req_b),
    .i_buff_rdata (buff_rdata_portB_i),
    .o_buff_wen   (buff_wen_portB_o),
    .o_buff_waddr (buff_waddr_portB_o),
    .o_buff_wdata (buff_wdata_portB_o),
    .o_buff_raddr (buff_raddr_portB_o),
    .o_rvalid     (bus.rd_rvalid_b_o),
    .o_rdata      (bus.rd_rdata_b_o)
  );

endmodule

// File: tb/tb_msgpass_buff_access_ctrl.sv
// Purpose : directed bench for msgpass_buff_access_ctrl with a dual-port buffer model and scoreboard.
// Latency : n/a.
// Backpr. : n/a.
module tb_msgpass_buff_access_ctrl;

  import msgpass_buff_access_ctrl_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  msgpass_buff_access_ctrl_if bus ();

  logic       wen_a, wen_b;
  addr_t      waddr_a, waddr_b, raddr_a, raddr_b;
  data_t      wdata_a, wdata_b;
  data_t      rdata_a = '0;
  data_t      rdata_b = '0;
  logic [3:0] cnt;

  msgpass_buff_access_ctrl #(.CONFLICT_CNT_WIDTH(4)) dut (
    .clk_i              (clk),
    .rstn               (rstn),
    .bus                (bus),
    .buff_wen_portA_o   (wen_a),
    .buff_waddr_portA_o (waddr_a),
    .buff_wdata_portA_o (wdata_a),
    .buff_raddr_portA_o (raddr_a),
    .buff_rdata_portA_i (rdata_a),
    .buff_wen_portB_o   (wen_b),
    .buff_waddr_portB_o (waddr_b),
    .buff_wdata_portB_o (wdata_b),
    .buff_raddr_portB_o (raddr_b),
    .buff_rdata_portB_i (rdata_b),
    .conflict_cnt_o     (cnt)
  );

  // Dual-port buffer: synchronous write, registered read (read-before-write on same edge).
  data_t mem [256];
  initial foreach (mem[i]) mem[i] = '0;
  always @(posedge clk) begin
    if (!wen_a) mem[waddr_a] <= wdata_a;
    if (!wen_b) mem[waddr_b] <= wdata_b;
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

  typedef struct { addr_t a; data_t d; int due; } wexp_t;
  typedef struct { data_t d; int due; } rexp_t;
  wexp_t wq_a[$], wq_b[$];
  rexp_t rq_a[$], rq_b[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: output seen with nothing expected (cycle %0d)", nm, cyc);
  endtask

  // Monitor: every strobe / response must match the oldest expectation, on its due cycle.
  initial forever begin
    wexp_t we;
    rexp_t re;
    @(negedge clk);
    if (rstn) begin
      if (!wen_a) begin
        if (wq_a.size() == 0) unexpected("wr_a");
        else begin
          we = wq_a.pop_front();
          chk("wr_a.addr", waddr_a, we.a);
          chk("wr_a.data", wdata_a, we.d);
          chk("wr_a.cycle", cyc, we.due);
        end
      end
      if (!wen_b) begin
        if (wq_b.size() == 0) unexpected("wr_b");
        else begin
          we = wq_b.pop_front();
          chk("wr_b.addr", waddr_b, we.a);
          chk("wr_b.data", wdata_b, we.d);
          chk("wr_b.cycle", cyc, we.due);
        end
      end
      if (bus.rd_rvalid_a_o) begin
        if (rq_a.size() == 0) unexpected("rd_a");
        else begin
          re = rq_a.pop_front();
          chk("rd_a.data", bus.rd_rdata_a_o, re.d);
          chk("rd_a.cycle", cyc, re.due);
        end
      end
      if (bus.rd_rvalid_b_o) begin
        if (rq_b.size() == 0) unexpected("rd_b");
        else begin
          re = rq_b.pop_front();
          chk("rd_b.data", bus.rd_rdata_b_o, re.d);
          chk("rd_b.cycle", cyc, re.due);
        end
      end
    end
  end

  // One cycle of stimulus. exp = expected ready {wr_a, wr_b, rd_a, rd_b} for channels driven valid.
  task automatic step(input string nm,
                      input logic wva, input addr_t waa, input data_t wda,
                      input logic wvb, input addr_t wab, input data_t wdb,
                      input logic rva, input addr_t raa,
                      input logic rvb, input addr_t rab,
                      input logic [3:0] exp, input data_t erda, input data_t erdb);
    int acc;
    @(negedge clk);
    bus.wr_valid_a_i = wva; bus.wr_addr_a_i = waa; bus.wr_data_a_i = wda;
    bus.wr_valid_b_i = wvb; bus.wr_addr_b_i = wab; bus.wr_data_b_i = wdb;
    bus.rd_valid_a_i = rva; bus.rd_addr_a_i = raa;
    bus.rd_valid_b_i = rvb; bus.rd_addr_b_i = rab;
    #1;
    acc = cyc + 1;
    if (wva) chk($sformatf("%s.wr_ready_a", nm), bus.wr_ready_a_o, exp[3]);
    if (wvb) chk($sformatf("%s.wr_ready_b", nm), bus.wr_ready_b_o, exp[2]);
    if (rva) chk($sformatf("%s.rd_ready_a", nm), bus.rd_ready_a_o, exp[1]);
    if (rvb) chk($sformatf("%s.rd_ready_b", nm), bus.rd_ready_b_o, exp[0]);
    if (wva && exp[3]) wq_a.push_back('{waa, wda, acc});
    if (wvb && exp[2]) wq_b.push_back('{wab, wdb, acc});
    if (rva && exp[1]) rq_a.push_back('{erda, acc + 2});
    if (rvb && exp[0]) rq_b.push_back('{erdb, acc + 2});
  endtask

  task automatic idle();
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk($sformatf("%s.wen_a", nm), wen_a, 1'b1);
    chk($sformatf("%s.wen_b", nm), wen_b, 1'b1);
    chk($sformatf("%s.waddr_a", nm), waddr_a, 0);
    chk($sformatf("%s.wdata_a", nm), wdata_a, 0);
    chk($sformatf("%s.raddr_a", nm), raddr_a, 0);
    chk($sformatf("%s.waddr_b", nm), waddr_b, 0);
    chk($sformatf("%s.wdata_b", nm), wdata_b, 0);
    chk($sformatf("%s.raddr_b", nm), raddr_b, 0);
    chk($sformatf("%s.rvalid_a", nm), bus.rd_rvalid_a_o, 1'b0);
    chk($sformatf("%s.rvalid_b", nm), bus.rd_rvalid_b_o, 1'b0);
    chk($sformatf("%s.cnt", nm), cnt, 0);
    chk($sformatf("%s.wr_ready_a", nm), bus.wr_ready_a_o, 1'b0);
    chk($sformatf("%s.wr_ready_b", nm), bus.wr_ready_b_o, 1'b0);
    chk($sformatf("%s.rd_ready_a", nm), bus.rd_ready_a_o, 1'b0);
    chk($sformatf("%s.rd_ready_b", nm), bus.rd_ready_b_o, 1'b0);
  endtask

  initial begin
    // Reset with all channels requesting: readies must stay low.
    bus.wr_valid_a_i = 1; bus.wr_addr_a_i = 1; bus.wr_data_a_i = 'h1;
    bus.wr_valid_b_i = 1; bus.wr_addr_b_i = 2; bus.wr_data_b_i = 'h2;
    bus.rd_valid_a_i = 1; bus.rd_addr_a_i = 3;
    bus.rd_valid_b_i = 1; bus.rd_addr_b_i = 4;
    #2 rstn = 0;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("reset");
    bus.wr_valid_a_i = 0; bus.wr_valid_b_i = 0;
    bus.rd_valid_a_i = 0; bus.rd_valid_b_i = 0;
    @(negedge clk);
    rstn = 1;

    // Single write then read back.
    step("w5",    1, 5, 'h11, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 0, 0);
    idle();
    step("r5",    0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 4'b0010, 'h11, 0);

    // Same-address write collisions: A first from reset, then alternating.
    step("col1",  1, 9, 'hA1, 1, 9, 'hB1, 0, 0, 0, 0, 4'b1000, 0, 0);
    step("col1b", 0, 0, 0,    1, 9, 'hB1, 0, 0, 0, 0, 4'b0100, 0, 0);
    chk("cnt.after_col1", cnt, 1);
    step("col2",  1, 9, 'hA2, 1, 9, 'hB2, 0, 0, 0, 0, 4'b0100, 0, 0);
    step("col2a", 1, 9, 'hA2, 0, 0, 0,    0, 0, 0, 0, 4'b1000, 0, 0);
    chk("cnt.after_col2", cnt, 2);
    step("col3",  1, 9, 'hA3, 1, 9, 'hB3, 0, 0, 0, 0, 4'b1000, 0, 0);
    step("col3b", 0, 0, 0,    1, 9, 'hB3, 0, 0, 0, 0, 4'b0100, 0, 0);
    chk("cnt.after_col3", cnt, 3);

    // Different addresses: both accepted, no count.
    step("nocol", 1, 'h20, 'h1234, 1, 'h21, 'h5678, 0, 0, 0, 0, 4'b1100, 0, 0);
    step("w3b",   0, 0, 0, 1, 3, 'h33, 0, 0, 0, 0, 4'b0100, 0, 0);
    chk("cnt.after_nocol", cnt, 3);

    // Single read then four back-to-back reads on A.
    step("r3",    0, 0, 0, 0, 0, 0, 1, 3,     0, 0, 4'b0010, 'h33, 0);
    step("bb0",   0, 0, 0, 0, 0, 0, 1, 5,     0, 0, 4'b0010, 'h11, 0);
    step("bb1",   0, 0, 0, 0, 0, 0, 1, 9,     0, 0, 4'b0010, 'hB3, 0);
    step("bb2",   0, 0, 0, 0, 0, 0, 1, 'h20, 0, 0, 4'b0010, 'h1234, 0);
    step("bb3",   0, 0, 0, 0, 0, 0, 1, 'h21, 0, 0, 4'b0010, 'h5678, 0);
    step("rr5",   0, 0, 0, 0, 0, 0, 1, 5,     1, 5, 4'b0011, 'h11, 'h11);

    // Read hazards and write-over-read priority.
    step("haz",    0, 0, 0, 1, 7, 'h77, 1, 7, 0, 0, 4'b0100, 0, 0);
    step("hazr",   0, 0, 0, 0, 0, 0,    1, 7, 0, 0, 4'b0010, 'h77, 0);
    step("samep",  1, 'h40, 'h44, 0, 0, 0, 1, 'h41, 0, 0, 4'b1000, 0, 0);
    step("xport",  0, 0, 0, 1, 'h50, 'h55, 1, 7, 0, 0, 4'b0110, 'h77, 0);
    step("rd4050", 0, 0, 0, 0, 0, 0, 1, 'h40, 1, 'h50, 4'b0011, 'h44, 'h55);

    // 19 more collisions: counter saturates at 15; grants alternate starting with B.
    for (int i = 0; i < 19; i++) begin
      step("sat", 1, 'h60, 'hAA, 1, 'h60, 'hBB, 0, 0, 0, 0,
           (i % 2 == 0) ? 4'b0100 : 4'b1000, 0, 0);
      chk($sformatf("cnt.sat%0d", i), cnt, (3 + i > 15) ? 15 : 3 + i);
    end
    idle();
    chk("cnt.saturated", cnt, 15);

    // Reset with a read in flight and a write just accepted.
    step("rdB5",  0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 4'b0001, 0, 'h11);
    step("wA70",  1, 'h70, 'h99, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 0, 0);
    @(posedge clk);
    #1 rstn = 0;
    wq_a.delete(); wq_b.delete(); rq_a.delete(); rq_b.delete();
    bus.wr_valid_a_i = 0; bus.wr_valid_b_i = 0;
    bus.rd_valid_a_i = 0; bus.rd_valid_b_i = 0;
    @(negedge clk);
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    rstn = 1;
    repeat (4) idle();
    // Priority returned to A; cancelled write at 0x70 never reached the buffer.
    step("pcol",  1, 'h71, 'h1, 1, 'h71, 'h2, 0, 0, 0, 0, 4'b1000, 0, 0);
    step("pcolb", 0, 0, 0, 1, 'h71, 'h2, 0, 0, 0, 0, 4'b0100, 0, 0);
    chk("cnt.after_reset", cnt, 1);
    step("r70",   0, 0, 0, 0, 0, 0, 1, 'h70, 0, 0, 4'b0010, 0, 0);
    repeat (6) idle();

    chk("left.wr_a", wq_a.size(), 0);
    chk("left.wr_b", wq_b.size(), 0);
    chk("left.rd_a", rq_a.size(), 0);
    chk("left.rd_b", rq_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
